// File: rtl/serial_parity_pkg.sv
// Shared FSM encoding and frame-length limit for serial_parity_accumulator.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      SPA_IDLE  = 2'd0,
      SPA_ACCUM = 2'd1,
      SPA_DONE  = 2'd2
   } spa_state_t;

   localparam int SPA_MAX_FRAME_LEN = 255;

endpackage

// File: rtl/serial_parity_accumulator.sv
// Running XOR parity over FRAME_LEN-bit serial frames, one result per frame via valid/ready.
// Define SPA_DATA_CAPTURE_EN to add out_data, the captured frame with its first bit in the LSB.
module serial_parity_accumulator
   import serial_parity_pkg::*;
#(
   parameter  int FRAME_LEN = 8,
   localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_bit,
   output logic                 in_ready,
   input  logic                 abort,
   output logic                 out_valid,
   output logic                 out_parity,
   input  logic                 out_ready,
`ifdef SPA_DATA_CAPTURE_EN
   output logic [FRAME_LEN-1:0] out_data,
`endif
   output logic [CNT_W-1:0]     bit_count
);

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam spa_state_t       FIRST_NEXT = (FRAME_LEN == 1) ? SPA_DONE : SPA_ACCUM;

   spa_state_t       state;
   logic             parity;
   logic [CNT_W-1:0] count;
   logic             xfer;
   logic             consume;

   // While a result is pending, input is accepted only when the result leaves in the same cycle.
   assign out_valid  = (state == SPA_DONE);
   assign in_ready   = (state == SPA_DONE) ? out_ready : 1'b1;
   assign xfer       = in_valid & in_ready;
   assign consume    = out_valid & out_ready;
   assign out_parity = out_valid & parity;
   assign bit_count  = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= SPA_IDLE;
         parity <= 1'b0;
         count  <= '0;
      end else if (abort) begin
         state  <= SPA_IDLE;
         parity <= 1'b0;
         count  <= '0;
      end else begin
         unique case (state)
            SPA_IDLE: begin
               if (xfer) begin
                  parity <= in_bit;
                  count  <= CNT_ONE;
                  state  <= FIRST_NEXT;
               end
            end
            SPA_ACCUM: begin
               if (xfer) begin
                  parity <= parity ^ in_bit;
                  count  <= count + CNT_ONE;
                  if (count + CNT_ONE == CNT_FULL) begin
                     state <= SPA_DONE;
                  end
               end
            end
            SPA_DONE: begin
               // A transfer alongside the consume opens the next frame with no bubble.
               if (consume) begin
                  if (xfer) begin
                     parity <= in_bit;
                     count  <= CNT_ONE;
                     state  <= FIRST_NEXT;
                  end else begin
                     parity <= 1'b0;
                     count  <= '0;
                     state  <= SPA_IDLE;
                  end
               end
            end
            default: begin
               state  <= SPA_IDLE;
               parity <= 1'b0;
               count  <= '0;
            end
         endcase
      end
   end

`ifdef SPA_DATA_CAPTURE_EN
   logic [FRAME_LEN-1:0] data;
   logic [CNT_W-1:0]     wr_idx;

   // A transfer in DONE always starts a new frame, so it lands in bit 0.
   assign wr_idx   = (state == SPA_DONE) ? '0 : count;
   assign out_data = data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (abort) begin
         data <= '0;
      end else if (xfer) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            if (wr_idx == CNT_W'(i)) begin
               data[i] <= in_bit;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_parity_accumulator.sv
// Randomized and directed bench for serial_parity_accumulator (FRAME_LEN=8 and FRAME_LEN=1 instances).
// Exercises out_data as well when SPA_DATA_CAPTURE_EN is defined.
module tb_serial_parity_accumulator;

   localparam int LEN_A = 8;
   localparam int LEN_B = 1;
   localparam int CW_A  = $clog2(LEN_A + 1);
   localparam int CW_B  = $clog2(LEN_B + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] in_valid = '0, in_bit = '0, abort = '0, out_ready = '0;
   logic [1:0] in_ready, out_valid, out_parity;
   logic [CW_A-1:0] bit_count_a;
   logic [CW_B-1:0] bit_count_b;
`ifdef SPA_DATA_CAPTURE_EN
   logic [LEN_A-1:0] out_data_a;
   logic [LEN_B-1:0] out_data_b;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_parity_accumulator #(.FRAME_LEN(LEN_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
      .in_ready(in_ready[0]), .abort(abort[0]), .out_valid(out_valid[0]),
      .out_parity(out_parity[0]), .out_ready(out_ready[0]),
`ifdef SPA_DATA_CAPTURE_EN
      .out_data(out_data_a),
`endif
      .bit_count(bit_count_a)
   );

   serial_parity_accumulator #(.FRAME_LEN(LEN_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
      .in_ready(in_ready[1]), .abort(abort[1]), .out_valid(out_valid[1]),
      .out_parity(out_parity[1]), .out_ready(out_ready[1]),
`ifdef SPA_DATA_CAPTURE_EN
      .out_data(out_data_b),
`endif
      .bit_count(bit_count_b)
   );

   // Reference model: bits of the frame in progress plus at most one pending result.
   int         m_len [2];
   int         m_cnt [2];
   logic [255:0] m_bits [2];
   bit         m_have [2];
   bit         m_par [2];
   logic [255:0] m_res [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]  = 0;
         m_bits[k] = '0;
         m_have[k] = 1'b0;
         m_par[k]  = 1'b0;
         m_res[k]  = '0;
      end
   endtask

   task automatic model_step(input int k);
      bit rdy;
      rdy = !m_have[k] || out_ready[k];
      if (abort[k]) begin
         m_cnt[k]  = 0;
         m_bits[k] = '0;
         m_have[k] = 1'b0;
         m_par[k]  = 1'b0;
         m_res[k]  = '0;
      end else begin
         if (m_have[k] && out_ready[k]) m_have[k] = 1'b0;
         if (in_valid[k] && rdy) begin
            m_bits[k][m_cnt[k]] = in_bit[k];
            m_cnt[k]++;
            if (m_cnt[k] == m_len[k]) begin
               m_have[k] = 1'b1;
               m_par[k]  = bit'($countones(m_bits[k]) % 2);
               m_res[k]  = m_bits[k];
               m_cnt[k]  = 0;
               m_bits[k] = '0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("a_out_valid", 32'(out_valid[0]), 32'(m_have[0]));
      check("a_in_ready", 32'(in_ready[0]), 32'(!m_have[0] || out_ready[0]));
      check("a_out_parity", 32'(out_parity[0]), 32'(m_have[0] ? m_par[0] : 1'b0));
      check("a_bit_count", 32'(bit_count_a), m_have[0] ? 32'(LEN_A) : 32'(m_cnt[0]));
      check("b_out_valid", 32'(out_valid[1]), 32'(m_have[1]));
      check("b_in_ready", 32'(in_ready[1]), 32'(!m_have[1] || out_ready[1]));
      check("b_out_parity", 32'(out_parity[1]), 32'(m_have[1] ? m_par[1] : 1'b0));
      check("b_bit_count", 32'(bit_count_b), m_have[1] ? 32'(LEN_B) : 32'(m_cnt[1]));
`ifdef SPA_DATA_CAPTURE_EN
      if (m_have[0]) check("a_out_data", 32'(out_data_a), 32'(m_res[0][LEN_A-1:0]));
      if (m_have[1]) check("b_out_data", 32'(out_data_b), 32'(m_res[1][LEN_B-1:0]));
`endif
   endtask

   // Drive inputs mid-cycle, then let them settle before checking.
   task automatic drive(input logic [1:0] iv, input logic [1:0] ib,
                        input logic [1:0] ab, input logic [1:0] ordy);
      in_valid  = iv;
      in_bit    = ib;
      abort     = ab;
      out_ready = ordy;
      #1;
   endtask

   task automatic drive_a(input logic iv, input logic ib, input logic ab, input logic ordy);
      drive({1'b0, iv}, {1'b0, ib}, {1'b0, ab}, {1'b1, ordy});
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic step_a(input logic iv, input logic ib, input logic ab, input logic ordy);
      drive_a(iv, ib, ab, ordy);
      check_all();
      tick();
   endtask

   task automatic send_byte_a(input logic [7:0] v);
      for (int i = 0; i < 8; i++) step_a(1'b1, v[i], 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1;
      logic [7:0] t2;
      m_len[0] = LEN_A;
      m_len[1] = LEN_B;
      model_reset();

      // Reset values.
      #2;
      drive(2'b00, 2'b00, 2'b00, 2'b11);
      check_all();
      check("rst_bit_count", 32'(bit_count_a), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame 1,0,1,1,0,0,1,0 with out_ready high.
      t1 = 8'b0100_1101;
      send_byte_a(t1);
      drive_a(1'b0, 1'b0, 1'b0, 1'b1);
      check_all();
      check("t1_valid", 32'(out_valid[0]), 32'd1);
      check("t1_parity", 32'(out_parity[0]), 32'd0);
      tick();
      step_a(1'b0, 1'b0, 1'b0, 1'b1);
      check("t1_idle", 32'(out_valid[0]), 32'd0);

      // Bits 1,1,1,0,0,0,0,0 gapped, then a 5-cycle stall.
      t2 = 8'b0000_0111;
      for (int i = 0; i < 8; i++) begin
         step_a(1'b1, t2[i], 1'b0, 1'b0);
         step_a(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         check_all();
         check("t2_stall_parity", 32'(out_parity[0]), 32'd1);
         check("t2_stall_ready", 32'(in_ready[0]), 32'd0);
         tick();
      end
      step_a(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back frames 0xFF then 0x01.
      for (int i = 0; i < 16; i++) begin
         drive_a(1'b1, (i < 8) ? 1'b1 : ((i == 8) ? 1'b1 : 1'b0), 1'b0, 1'b1);
         check_all();
         if (i == 8) begin
            check("t3_done_ready", 32'(in_ready[0]), 32'd1);
            check("t3_f1_parity", 32'(out_parity[0]), 32'd0);
         end
         tick();
      end
      drive_a(1'b0, 1'b0, 1'b0, 1'b1);
      check_all();
      check("t3_f2_parity", 32'(out_parity[0]), 32'd1);
      tick();

      // Abort after 5 bits, then 0x80.
      for (int i = 0; i < 5; i++) step_a(1'b1, 1'b1, 1'b0, 1'b1);
      step_a(1'b1, 1'b1, 1'b1, 1'b1);
      check("t4_after_abort", 32'(bit_count_a), 32'd0);
      send_byte_a(8'h80);
      drive_a(1'b0, 1'b0, 1'b0, 1'b0);
      check_all();
      check("t4_parity", 32'(out_parity[0]), 32'd1);
      check("t4_bit_count", 32'(bit_count_a), 32'd8);
      tick();
      step_a(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SPA_DATA_CAPTURE_EN
      send_byte_a(8'hA5);
      drive_a(1'b0, 1'b0, 1'b0, 1'b1);
      check_all();
      check("cap_data", 32'(out_data_a), 32'h0000_00A5);
      check("cap_parity", 32'(out_parity[0]), 32'd0);
      tick();
`endif

      // Asynchronous reset after 3 bits.
      for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, 1'b0, 1'b1);
      drive_a(1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", 32'(out_valid[0]), 32'd0);
      check("t5_async_count", 32'(bit_count_a), 32'd0);
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FRAME_LEN=1: stream 1,0,1.
      for (int i = 0; i < 4; i++) begin
         drive({(i < 3) ? 1'b1 : 1'b0, 1'b0}, {(i == 1) ? 1'b0 : 1'b1, 1'b0}, 2'b00, 2'b11);
         check_all();
         if (i > 0) begin
            check("t6_valid", 32'(out_valid[1]), 32'd1);
            check("t6_parity", 32'(out_parity[1]), (i == 2) ? 32'd0 : 32'd1);
         end
         tick();
      end

      // Random traffic on both instances.
      for (int n = 0; n < 2000; n++) begin
         drive({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
               2'($urandom_range(0, 3)),
               {1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 31) == 0)},
               {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0)});
         check_all();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
